// File: rtl/dual_port_ram_pipe.sv
// Purpose : true dual-port RAM, ports A and B share one array and one clock, each with its own write and read pipelines.
// Latency : a write commits WRITE_LANTENCY-1 edges after sampling; read data lands on o_dout READ_LANTENCY-1 edges after sampling.
// Backpr. : none; each port accepts one command per cycle, and both ports can issue commands every cycle.
//
// Ports:
//   i_clk, i_rst_n                   clock (rising edge), asynchronous active-low reset
//   i_ena/i_wea/i_addra/i_dina       port A command: en=1,we=1 write; en=1,we=0 read; en=0 idle
//   i_enb/i_web/i_addrb/i_dinb       port B command, same encoding
//   o_douta, o_doutb                 last read result per port, held until the next read completes
module dual_port_ram_pipe #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int READ_LANTENCY  = 3,
    parameter int WRITE_LANTENCY = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_dina,
    input  logic [ADDR_WIDTH-1:0] i_addra,
    input  logic                  i_ena,
    input  logic                  i_wea,
    input  logic [DATA_WIDTH-1:0] i_dinb,
    input  logic [ADDR_WIDTH-1:0] i_addrb,
    input  logic                  i_enb,
    input  logic                  i_web,
    output logic [DATA_WIDTH-1:0] o_douta,
    output logic [DATA_WIDTH-1:0] o_doutb
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Pipeline depths.  When a latency is 1, its pipe is never used, but the array keeps at least one entry so it stays legal.
    localparam int WP = (WRITE_LANTENCY > 1) ? WRITE_LANTENCY - 1 : 1;
    localparam int RP = (READ_LANTENCY  > 1) ? READ_LANTENCY  - 1 : 1;

    // Index 0 is port A and index 1 is port B, so both ports share the same code.
    logic [1:0]            en;
    logic [1:0]            we;
    logic [ADDR_WIDTH-1:0] addr [2];
    logic [DATA_WIDTH-1:0] din  [2];

    assign en      = {i_enb, i_ena};
    assign we      = {i_web, i_wea};
    assign addr[0] = i_addra;
    assign addr[1] = i_addrb;
    assign din[0]  = i_dina;
    assign din[1]  = i_dinb;

    logic [DATA_WIDTH-1:0] mem_q     [DEPTH];
    logic                  wp_vld_q  [2][WP];
    logic [ADDR_WIDTH-1:0] wp_addr_q [2][WP];
    logic [DATA_WIDTH-1:0] wp_dat_q  [2][WP];
    logic                  rp_vld_q  [2][RP];
    logic [DATA_WIDTH-1:0] rp_dat_q  [2][RP];
    logic [DATA_WIDTH-1:0] dout_q    [2];

    logic [1:0]            rd_vld_d;
    logic [DATA_WIDTH-1:0] rd_dat_d  [2];
    logic [1:0]            cm_vld_d;
    logic [ADDR_WIDTH-1:0] cm_addr_d [2];
    logic [DATA_WIDTH-1:0] cm_dat_d  [2];
    logic [1:0]            fin_vld_d;
    logic [DATA_WIDTH-1:0] fin_dat_d [2];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            // The array is read before this edge's commit lands, so a read that collides with a commit returns the old word.
            rd_vld_d[p] = en[p] & ~we[p];
            rd_dat_d[p] = mem_q[addr[p]];
            if (WRITE_LANTENCY == 1) begin
                cm_vld_d[p]  = en[p] & we[p];
                cm_addr_d[p] = addr[p];
                cm_dat_d[p]  = din[p];
            end else begin
                cm_vld_d[p]  = wp_vld_q[p][WP-1];
                cm_addr_d[p] = wp_addr_q[p][WP-1];
                cm_dat_d[p]  = wp_dat_q[p][WP-1];
            end
            if (READ_LANTENCY == 1) begin
                fin_vld_d[p] = rd_vld_d[p];
                fin_dat_d[p] = rd_dat_d[p];
            end else begin
                fin_vld_d[p] = rp_vld_q[p][RP-1];
                fin_dat_d[p] = rp_dat_q[p][RP-1];
            end
        end
    end

    // Write and read pipelines, plus the output hold registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < WP; k++) begin
                    wp_vld_q[p][k]  <= 1'b0;
                    wp_addr_q[p][k] <= '0;
                    wp_dat_q[p][k]  <= '0;
                end
                for (int k = 0; k < RP; k++) begin
                    rp_vld_q[p][k] <= 1'b0;
                    rp_dat_q[p][k] <= '0;
                end
                dout_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                wp_vld_q[p][0]  <= en[p] & we[p];
                wp_addr_q[p][0] <= addr[p];
                wp_dat_q[p][0]  <= din[p];
                for (int k = 1; k < WP; k++) begin
                    wp_vld_q[p][k]  <= wp_vld_q[p][k-1];
                    wp_addr_q[p][k] <= wp_addr_q[p][k-1];
                    wp_dat_q[p][k]  <= wp_dat_q[p][k-1];
                end
                rp_vld_q[p][0] <= rd_vld_d[p];
                rp_dat_q[p][0] <= rd_dat_d[p];
                for (int k = 1; k < RP; k++) begin
                    rp_vld_q[p][k] <= rp_vld_q[p][k-1];
                    rp_dat_q[p][k] <= rp_dat_q[p][k-1];
                end
                // The output changes only when a read finishes, and otherwise holds its last value.
                if (fin_vld_d[p]) begin
                    dout_q[p] <= fin_dat_d[p];
                end
            end
        end
    end

    // Storage array.  Port A's commit comes last, so it wins when both ports commit to the same address on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (cm_vld_d[1]) begin
                mem_q[cm_addr_d[1]] <= cm_dat_d[1];
            end
            if (cm_vld_d[0]) begin
                mem_q[cm_addr_d[0]] <= cm_dat_d[0];
            end
        end
    end

    assign o_douta = dout_q[0];
    assign o_doutb = dout_q[1];

endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// Bench for dual_port_ram_pipe with default parameters.
// Expected read data comes from hand-derived constants in the command table and loops.
// Each read pushes its expected value with a due edge, and the bench compares both outputs every cycle.
module tb_dual_port_ram_pipe;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int RL = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] dina, dinb;
    logic [AW-1:0] addra, addrb;
    logic          ena, wea, enb, web;
    logic [DW-1:0] douta, doutb;

    always #5 clk = ~clk;

    dual_port_ram_pipe dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_dina  (dina),
        .i_addra (addra),
        .i_ena   (ena),
        .i_wea   (wea),
        .i_dinb  (dinb),
        .i_addrb (addrb),
        .i_enb   (enb),
        .i_web   (web),
        .o_douta (douta),
        .o_doutb (doutb)
    );

    typedef struct {
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp;   // expected read data; meaningful for reads only
    } cmd_t;

    typedef struct {
        cmd_t a;
        cmd_t b;
    } vec_t;

    typedef struct {
        int            due;
        logic [DW-1:0] val;
    } sb_t;

    localparam int NVEC = 23;
    vec_t          tbl [NVEC];
    sb_t           sbq_a [$];
    sb_t           sbq_b [$];
    logic [DW-1:0] exp_a, exp_b;
    int            edge_n;
    int            n_checks;
    int            n_pass;

    function automatic cmd_t nop();
        cmd_t c;
        c.en = 1'b0; c.we = 1'b0; c.addr = '0; c.din = '0; c.exp = '0;
        return c;
    endfunction

    function automatic cmd_t wr(int a, logic [DW-1:0] d);
        cmd_t c;
        c.en = 1'b1; c.we = 1'b1; c.addr = AW'(a); c.din = d; c.exp = '0;
        return c;
    endfunction

    function automatic cmd_t rd(int a, logic [DW-1:0] e);
        cmd_t c;
        c.en = 1'b1; c.we = 1'b0; c.addr = AW'(a); c.din = '0; c.exp = e;
        return c;
    endfunction

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    // One clock: drive the inputs at the negedge, let the DUT sample at the posedge, then check at the next negedge.
    task automatic step(cmd_t a, cmd_t b);
        sb_t e;
        ena = a.en; wea = a.we; addra = a.addr; dina = a.din;
        enb = b.en; web = b.we; addrb = b.addr; dinb = b.din;
        @(posedge clk);
        edge_n++;
        if (rst_n && a.en && !a.we) begin
            e.due = edge_n + RL - 1; e.val = a.exp; sbq_a.push_back(e);
        end
        if (rst_n && b.en && !b.we) begin
            e.due = edge_n + RL - 1; e.val = b.exp; sbq_b.push_back(e);
        end
        @(negedge clk);
        if (sbq_a.size() > 0 && sbq_a[0].due == edge_n) begin
            exp_a = sbq_a[0].val; void'(sbq_a.pop_front());
        end
        if (sbq_b.size() > 0 && sbq_b[0].due == edge_n) begin
            exp_b = sbq_b[0].val; void'(sbq_b.pop_front());
        end
        check($sformatf("douta@edge%0d", edge_n), douta, exp_a);
        check($sformatf("doutb@edge%0d", edge_n), doutb, exp_b);
    endtask

    // Assert reset in mid-cycle and check that the outputs clear at once, without waiting for a clock edge.
    task automatic mid_reset(string tag);
        rst_n = 1'b0;
        #1;
        sbq_a.delete();
        sbq_b.delete();
        exp_a = '0;
        exp_b = '0;
        check({tag, "_douta_immediate"}, douta, '0);
        check({tag, "_doutb_immediate"}, doutb, '0);
        step(nop(), nop());
        step(nop(), nop());
        rst_n = 1'b1;
    endtask

    task automatic set_row(int i, cmd_t a, cmd_t b);
        tbl[i].a = a;
        tbl[i].b = b;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; edge_n = 0;
        exp_a = '0; exp_b = '0;
        rst_n = 1'b1;
        ena = 0; wea = 0; addra = '0; dina = '0;
        enb = 0; web = 0; addrb = '0; dinb = '0;

        // Write commits 2 edges after sampling.  Reads sampled 0..2 edges after the write see old data, and 3 or more see new data.
        set_row( 0, wr(1, 32'h0000_0012),  nop());
        set_row( 1, rd(1, 32'h0),          nop());
        set_row( 2, rd(1, 32'h0),          wr(3, 32'h0000_0013));   // A read on the commit edge of addr 1 sees the old word
        set_row( 3, rd(1, 32'h12),         nop());
        set_row( 4, rd(1, 32'h12),         rd(3, 32'h0));           // B read on the commit edge of addr 3 sees the old word
        set_row( 5, rd(3, 32'h13),         rd(1, 32'h12));
        set_row( 6, wr(7, 32'hAAAA_0000),  wr(7, 32'h0000_BBBB));   // both ports write the same address
        set_row( 7, rd(7, 32'h0),          rd(7, 32'h0));
        set_row( 8, rd(7, 32'h0),          nop());                  // read on the commit edge
        set_row( 9, nop(),                 rd(7, 32'hAAAA_0000));   // port A wins the collision
        set_row(10, rd(7, 32'hAAAA_0000),  wr(7, 32'h0000_0055));
        set_row(11, nop(),                 nop());
        set_row(12, rd(7, 32'hAAAA_0000),  nop());                  // read on the commit edge of B's write
        set_row(13, rd(7, 32'h55),         rd(3, 32'h13));
        set_row(14, nop(),                 nop());                  // output holds
        set_row(15, nop(),                 nop());
        set_row(16, wr(2, 32'h22),         wr(4, 32'h44));
        set_row(17, nop(),                 nop());
        set_row(18, nop(),                 nop());
        set_row(19, rd(4, 32'h44),         rd(2, 32'h22));
        set_row(20, nop(),                 nop());
        set_row(21, nop(),                 nop());
        set_row(22, nop(),                 nop());

        @(negedge clk);
        mid_reset("reset0");

        // After reset, every address reads back as zero.
        for (int i = 0; i < 32; i++) step(rd(i, 32'h0), rd(31 - i, 32'h0));

        for (int i = 0; i < NVEC; i++) step(tbl[i].a, tbl[i].b);

        // Throughput: fill the array with data = address, then stream reads on consecutive cycles.
        for (int i = 0; i < 16; i++) step(wr(i, DW'(i)), wr(i + 16, DW'(i + 16)));
        step(nop(), nop());
        step(nop(), nop());
        for (int i = 0; i < 32; i++) step(rd(i, DW'(i)), rd(31 - i, DW'(31 - i)));
        for (int i = 0; i < 3; i++) step(nop(), nop());

        // Reset while a read of addr 10 and a write of 0xDEADBEEF to addr 5 are still in flight.
        step(rd(10, 32'd10), nop());
        step(wr(5, 32'hDEAD_BEEF), nop());
        mid_reset("reset1");
        step(rd(5, 32'h0), rd(10, 32'h0));
        step(nop(), rd(5, 32'h0));
        for (int i = 0; i < 4; i++) step(nop(), nop());

        check("sb_a_drained", DW'(sbq_a.size()), '0);
        check("sb_b_drained", DW'(sbq_b.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
